// File: rtl/branch_pc_sequencer_if.sv
// Instruction-memory fetch channel between the PC sequencer and the fetch port.
interface branch_pc_sequencer_if;
  logic        oIMEM_REQ;
  logic [31:0] oIMEM_ADDR;
  logic        iIMEM_ACK;
  logic [31:0] iIMEM_DATA;

  // Sequencer side: issues requests, receives instruction words.
  modport master (
    output oIMEM_REQ,
    output oIMEM_ADDR,
    input  iIMEM_ACK,
    input  iIMEM_DATA
  );

  // Memory side: observes requests, returns instruction words.
  modport slave (
    input  oIMEM_REQ,
    input  oIMEM_ADDR,
    output iIMEM_ACK,
    output iIMEM_DATA
  );
endinterface

// File: rtl/branch_pc_sequencer.sv
// RV32I program-counter sequencer: fetch / decode / exec control with
// branch and JAL target selection, misalignment trap and retire counter.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic                         iRUN,
  branch_pc_sequencer_if.master        imem,
  output logic [31:0]                  oIR,
  output logic [31:0]                  oPC,
  output logic [31:0]                  oLINK,
  input  logic                         iHOLD,
  input  logic                         iBR_TAKEN,
  input  logic [31:0]                  iBR_OFFSET,
  output logic                         oEXEC,
  output logic                         oTRAP,
  output logic [31:0]                  oRETIRED
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 7;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
  localparam logic [XLEN-1:0]  INSN_BYTES = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_TRAP   = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_req;
  logic            r_exec;
  logic            r_trap;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_link;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_retired;

  logic [OPC_W-1:0] w_opcode;
  logic [XLEN-1:0]  w_jal_imm;
  logic [XLEN-1:0]  w_offset;
  logic [XLEN-1:0]  w_next;
  logic             w_misaligned;

  // Next-PC selection from the latched instruction and the branch verdict.
  always_comb begin
    w_opcode  = r_ir[OPC_W-1:0];
    w_jal_imm = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    w_offset  = INSN_BYTES;
    if (w_opcode == OP_BRANCH && iBR_TAKEN) begin
      w_offset = iBR_OFFSET;
    end else if (w_opcode == OP_JAL) begin
      w_offset = w_jal_imm;
    end
    w_next       = r_pc + w_offset;
    w_misaligned = |w_next[1:0];
  end

  // Control FSM with registered strobes, PC, IR and retire count.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_exec    <= 1'b0;
      r_trap    <= 1'b0;
      r_pc      <= RESET_PC;
      r_link    <= RESET_PC + INSN_BYTES;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iRUN) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem.iIMEM_ACK) begin
            r_ir    <= imem.iIMEM_DATA;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
          r_exec  <= 1'b1;
        end
        S_EXEC: begin
          if (!iHOLD) begin
            r_exec <= 1'b0;
            if (w_misaligned) begin
              // PC and counter stay on the faulting instruction.
              r_trap  <= 1'b1;
              r_state <= S_TRAP;
            end else begin
              r_pc      <= w_next;
              r_link    <= w_next + INSN_BYTES;
              r_retired <= r_retired + 32'd1;
              if (iRUN) begin
                r_state <= S_FETCH;
                r_req   <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_TRAP: begin
          r_state <= S_TRAP;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_exec  <= 1'b0;
        end
      endcase
    end
  end

  assign imem.oIMEM_REQ  = r_req;
  assign imem.oIMEM_ADDR = r_pc;
  assign oIR             = r_ir;
  assign oPC             = r_pc;
  assign oLINK           = r_link;
  assign oEXEC           = r_exec;
  assign oTRAP           = r_trap;
  assign oRETIRED        = r_retired;

endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
- Multi-cycle control FSM that owns the program counter of the RV32I core.
- Fetches each instruction over a req/ack instruction-memory handshake and latches it as oIR for the decode units (including the type-B branch unit).
- Samples the branch unit's resolved decision and offset, then computes the next PC: sequential, conditional branch, or JAL.
- Flags misaligned targets and keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- iCLK  input  1  core clock, all state changes on posedge.
- iRST_N  input  1  asynchronous active-low reset.
- iRUN  input  1  start/continue execution.
- oIMEM_REQ  output  1  fetch request.
- oIMEM_ADDR  output  32  fetch address, equal to oPC.
- iIMEM_ACK  input  1  fetch data valid this cycle.
- iIMEM_DATA  input  32  fetched instruction word.
- oIR  output  32  latched instruction, feeding the decode and branch units.
- oPC  output  32  PC of the instruction in oIR.
- oLINK  output  32  oPC+4, the JAL link value.
- iHOLD  input  1  stall request from the datapath, e.g. register-file busy.
- iBR_TAKEN  input  1  branch condition result from the branch unit.
- iBR_OFFSET  input  32  signed byte offset from the branch unit.
- oEXEC  output  1  high during the EXEC state (writeback strobe).
- oTRAP  output  1  misaligned-target trap, sticky.
- oRETIRED  output  32  count of retired instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, TRAP. All registers change only on posedge iCLK, except reset.
- Reset (iRST_N=0, asynchronous, takes effect immediately, including mid-fetch or mid-exec):
  - state=IDLE, PC=RESET_PC, oIR=0, oTRAP=0, oRETIRED=0.
  - oIMEM_REQ=0, oEXEC=0.
- oIMEM_REQ = (state==FETCH). oEXEC = (state==EXEC). oIMEM_ADDR = oPC. oLINK = oPC+32'd4, modulo 2^32.
- IDLE -> FETCH when iRUN=1; otherwise stay in IDLE.
- FETCH:
  - Hold oIMEM_REQ high and oIMEM_ADDR stable until iIMEM_ACK=1.
  - On the ack cycle: oIR<=iIMEM_DATA, then go to DECODE.
  - iIMEM_ACK is ignored in every state other than FETCH.
  - iRUN is not checked in FETCH.
- DECODE: exactly 1 cycle, which allows the register-file read to settle. Then go to EXEC.
- EXEC, with iHOLD=1: stay in EXEC. PC, oIR and the counter are unchanged.
- EXEC, with iHOLD=0, the next PC is selected as follows:
  - oIR[6:0]==7'h63 and iBR_TAKEN=1: next = PC + iBR_OFFSET.
  - oIR[6:0]==7'h6F (JAL): next = PC + {{12{oIR[31]}}, oIR[19:12], oIR[20], oIR[30:21], 1'b0}.
  - Otherwise (including a not-taken branch): next = PC + 4.
  - All adds are 32-bit and wrap modulo 2^32. iBR_TAKEN and iBR_OFFSET are ignored for non-0x63 opcodes.
- EXEC exit, aligned target (next[1:0]==0):
  - PC<=next; oRETIRED<=oRETIRED+1, wrapping 0xFFFF_FFFF -> 0.
  - Next state is FETCH if iRUN=1, IDLE if iRUN=0.
- EXEC exit, misaligned target (next[1:0]!=0):
  - PC unchanged, counter unchanged, oTRAP<=1, state=TRAP.
- TRAP: absorbing; only reset leaves it. oIMEM_REQ=0.
- Latency: 3 cycles per instruction with a zero-wait ack (FETCH, DECODE, EXEC), plus 1 cycle per ack wait state and 1 cycle per iHOLD cycle.
- iHOLD is honoured only in EXEC. iRUN is sampled only in IDLE and at EXEC exit.

Test Plan:
- Reset/start: RESET_PC=0x100; release iRST_N with iRUN=0 for 5 cycles -> oIMEM_REQ=0, oPC=0x100. Assert iRUN -> oIMEM_REQ=1 next cycle with oIMEM_ADDR=0x100.
- Sequential with wait states: ack delayed 2 cycles with data 0x00000013 -> req held 3 cycles with a stable address; oIR=0x13. After EXEC: oPC=0x104, oRETIRED=1.
- Branch taken/not-taken: at PC=0x10, oIR=0x00000063.
  - iBR_TAKEN=1, iBR_OFFSET=0xFFFFFFF8 -> next fetch address 0x08.
  - Repeat with iBR_TAKEN=0 -> next fetch address 0x14.
- JAL: oIR=0x008000EF at PC=0x20 -> oLINK=0x24 during EXEC; next fetch address 0x28; iBR_* ignored.
- Hold and stop: iHOLD=1 for 4 cycles in EXEC -> oEXEC high 5 cycles, PC unchanged until release. Deassert iRUN during EXEC -> goes to IDLE, no further request.
- Trap and async reset: branch at 0x40 with offset 0x6 -> oTRAP=1, oPC stays 0x40, no further request, counter frozen. Pulse iRST_N low mid-FETCH (between clock edges) -> oIMEM_REQ and oTRAP drop immediately; PC=RESET_PC.
